mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
Sequencer that sits between the execute stage and the 32-cycle Booth multiplier. It accepts one multiply request at a time over a valid/ready handshake and registers the operands. It then pulses the multiplier start, tracks the iteration count and captures the 32-bit product and exception flag. It also returns a response over a valid/ready handshake, supports pipeline flush, and applies a watchdog if the multiplier never reports ready.

Parameters:
MUL_LATENCY, 32, cycles from the start pulse to the multiplier's ready indication.
TIMEOUT_SLACK, 4, extra cycles allowed past MUL_LATENCY before the watchdog fires.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  synchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_a  input  32  multiplicand.
req_b  input  32  multiplier.
flush  input  1  cancel any in-flight or pending-response operation.
resp_valid  output  1  result available.
resp_ready  input  1  consumer accepts result.
resp_prod  output  32  product bits [31:0].
resp_exc  output  1  product overflowed 32 bits (signed).
resp_timeout  output  1  watchdog fired; resp_prod is 0.
busy  output  1  high in any state other than IDLE (pipeline stall).
mul_start  output  1  drives the multiplier's start input.
mul_a  output  32  drives the multiplier's multiplicand.
mul_b  output  32  drives the multiplier's multiplier operand.
mul_ready  input  1  multiplier result valid (combinational from the multiplier).
mul_exc  input  1  multiplier exception.
mul_out  input  32  multiplier product.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on reset_n.
- Reset: state goes to IDLE. All of req_ready=1, resp_valid=0, resp_prod=0, resp_exc=0, resp_timeout=0, busy=0 and mul_start=0. The operand registers are cleared to 0.
- States are IDLE, START, BUSY and RESP.
- IDLE: req_ready=1. On req_valid, latch req_a/req_b and move to START.
- START: exactly one cycle. mul_start=1, and mul_a/mul_b are driven from the latched operands. The cycle counter loads with 0. Next state is BUSY.
- BUSY: mul_start=0, and mul_a/mul_b hold the latched values. The counter increments each cycle.
  - On mul_ready=1, capture mul_out into resp_prod and mul_exc into resp_exc, then move to RESP.
  - mul_ready is ignored in every state except BUSY (the multiplier counter is undefined before the first start).
  - The nominal handshake is: request accepted at cycle T, mul_start at T+1, mul_ready at T+1+MUL_LATENCY, resp_valid at T+2+MUL_LATENCY (34 cycles after acceptance).
- Watchdog: in BUSY, if the counter reaches MUL_LATENCY+TIMEOUT_SLACK with no mul_ready, set resp_timeout=1, resp_prod=0 and resp_exc=0, then move to RESP.
- RESP: resp_valid=1 and the outputs are held stable. On resp_ready, go to IDLE. A new request is not accepted in the same cycle; req_ready is 1 only in IDLE.
- Flush: flush takes priority over every transition except reset. In any state it forces IDLE on the next edge and clears resp_valid. A result captured in the flush cycle is discarded. The multiplier is left running; it is reloaded by the next mul_start.
- Flush and req_valid in the same IDLE cycle: the request is not accepted.
- Simultaneous watchdog expiry and mul_ready: mul_ready wins, with normal capture and resp_timeout=0.
- resp_timeout and resp_exc are cleared on every entry to START.

Optional Feature:
MUL_ZERO_SKIP_EN.
- Defined: in IDLE, if req_valid and either req_a or req_b is 0, go directly to RESP. In that case resp_prod=0 and resp_exc=0, mul_start is never asserted, and resp_valid is asserted 1 cycle after acceptance.
- Undefined: every request goes through START and BUSY.

Decomposition:
- Shared package mul_ctrl_pkg holds:
  - the state encoding constants (IDLE=2'd0, START=2'd1, BUSY=2'd2, RESP=2'd3);
  - the default MUL_LATENCY;
  - the counter width (6 bits).
- One natural sub-module, mul_cycle_counter: a 6-bit counter with synchronous clear, enable, and a terminal-compare output. It is reused for the watchdog compare.

Test Plan:
- A=7, B=6 with resp_ready held 1: mul_start high for exactly one cycle at T+1; resp_valid at T+34; resp_prod=42, resp_exc=0; busy high T+1..T+34.
- A=0x40000000, B=4: resp_exc=1 at response; then A=-3, B=5 back-to-back: resp_prod=0xFFFFFFF1, resp_exc=0, and resp_exc is cleared from the previous operation.
- Hold resp_ready=0 for 10 cycles after resp_valid: resp_valid, resp_prod and resp_exc stay stable, and req_ready=0 throughout; a single resp_ready pulse returns to IDLE.
- Assert flush at BUSY cycle 15, then issue A=3, B=3: no response for the flushed operation; the new operation yields 9 after 34 cycles.
- Model mul_ready stuck low: resp_timeout=1 and resp_prod=0 at MUL_LATENCY+TIMEOUT_SLACK (36) BUSY cycles.
- With MUL_ZERO_SKIP_EN, A=0, B=123: resp_valid 1 cycle after acceptance, mul_start never high. Without MUL_ZERO_SKIP_EN: 34-cycle latency with a product of 0.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiply issue controller: the state encoding,
// the default multiplier latency and watchdog slack, and the cycle counter width.
package mul_ctrl_pkg;

    localparam int MUL_LATENCY_DEF   = 32;
    localparam int TIMEOUT_SLACK_DEF = 4;
    localparam int CNT_W             = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } mul_state_e;

endpackage

// File: rtl/mul_cycle_counter.sv
// Small cycle counter with synchronous clear and enable. The terminal output is
// high while the count equals TERMINAL; the controller uses it as its watchdog.
module mul_cycle_counter
    import mul_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] TERMINAL = CNT_W'(MUL_LATENCY_DEF + TIMEOUT_SLACK_DEF - 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable so a fresh operation always starts counting from zero
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == TERMINAL);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller between the execute stage and the iterative Booth multiplier.
// Accepts one request, pulses the multiplier start, waits for its ready (with a
// watchdog), then holds the response until the consumer takes it. Flush returns
// to IDLE from any state.
// Optional build macro MUL_ZERO_SKIP_EN: a request with a zero operand bypasses
// the multiplier and responds with a zero product one cycle after acceptance.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY   = MUL_LATENCY_DEF,
    parameter int TIMEOUT_SLACK = TIMEOUT_SLACK_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_prod,
    output logic        resp_exc,
    output logic        resp_timeout,
    output logic        busy,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ready,
    input  logic        mul_exc,
    input  logic [31:0] mul_out
);

    // The counter is cleared in START and reads 0 in the first BUSY cycle, so
    // comparing against limit-1 fires in the last allowed BUSY cycle.
    localparam logic [CNT_W-1:0] WDOG_TERM = CNT_W'(MUL_LATENCY + TIMEOUT_SLACK - 1);

    mul_state_e  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] prod_q, prod_d;
    logic        exc_q, exc_d;
    logic        tmo_q, tmo_d;
    logic        cnt_clear;
    logic        cnt_enable;
    logic        wdog_hit;
    logic        zero_op;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (req_a == 32'd0) || (req_b == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    mul_cycle_counter #(
        .TERMINAL (WDOG_TERM)
    ) u_cycle_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (wdog_hit)
    );

    // Next-state, operand/result capture and counter control; flush overrides all
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        prod_d     = prod_q;
        exc_d      = exc_q;
        tmo_d      = tmo_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_d   = req_a;
                        b_d   = req_b;
                        exc_d = 1'b0;
                        tmo_d = 1'b0;
                        if (zero_op) begin
                            prod_d  = 32'd0;
                            state_d = RESP;
                        end else begin
                            state_d = START;
                        end
                    end
                end
                START: begin
                    cnt_clear = 1'b1;
                    state_d   = BUSY;
                end
                BUSY: begin
                    cnt_enable = 1'b1;
                    if (mul_ready) begin
                        prod_d  = mul_out;
                        exc_d   = mul_exc;
                        tmo_d   = 1'b0;
                        state_d = RESP;
                    end else if (wdog_hit) begin
                        prod_d  = 32'd0;
                        exc_d   = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Handshake and multiplier outputs decoded from the current state
    always_comb begin
        req_ready    = (state_q == IDLE);
        resp_valid   = (state_q == RESP);
        busy         = (state_q != IDLE);
        mul_start    = (state_q == START);
        mul_a        = a_q;
        mul_b        = b_q;
        resp_prod    = prod_q;
        resp_exc     = exc_q;
        resp_timeout = tmo_q;
    end

    // State, operand and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            exc_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            exc_q   <= exc_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural Booth multiplier model.
module tb_mul_issue_ctrl;

    localparam int LAT   = 32;
    localparam int SLACK = 4;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_prod;
    logic        resp_exc;
    logic        resp_timeout;
    logic        busy;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic        mul_exc;
    logic [31:0] mul_out;

    typedef struct {
        logic [31:0] prod;
        logic        exc;
        logic        tmo;
        int          lat;
        int          starts;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int busy_cnt = 0;
    int start_cnt = 0;
    logic tracking = 1'b0;
    logic in_resp = 1'b0;
    logic mul_stuck = 1'b0;

    mul_issue_ctrl #(
        .MUL_LATENCY   (LAT),
        .TIMEOUT_SLACK (SLACK)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_prod    (resp_prod),
        .resp_exc     (resp_exc),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_ready    (mul_ready),
        .mul_exc      (mul_exc),
        .mul_out      (mul_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: ready LAT cycles after the start pulse, reloaded by every start
    logic        m_active = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [63:0] m_p;

    always @(posedge clk) begin
        if (mul_start) begin
            m_active <= 1'b1;
            m_cnt    <= 1;
            m_a      <= mul_a;
            m_b      <= mul_b;
        end else if (m_active) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign m_p       = {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
    assign mul_out   = m_p[31:0];
    assign mul_exc   = (m_p[63:31] != {33{m_p[31]}});
    assign mul_ready = m_active && (m_cnt == LAT) && !mul_stuck;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            passes++;
        end
    endtask

    function automatic exp_t makeExpected(input logic [31:0] a, input logic [31:0] b, input logic stuck);
        exp_t   e;
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        e.prod   = p[31:0];
        e.exc    = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        e.tmo    = 1'b0;
        e.lat    = LAT + 2;
        e.starts = 1;
`ifdef MUL_ZERO_SKIP_EN
        if (a == 32'd0 || b == 32'd0) begin
            e.lat    = 1;
            e.starts = 0;
        end
`endif
        if (stuck && e.starts == 1) begin
            e.prod = 32'd0;
            e.exc  = 1'b0;
            e.tmo  = 1'b1;
            e.lat  = LAT + SLACK + 2;
        end
        return e;
    endfunction

    // Scoreboard monitor: counts busy/start cycles, checks each response, pushes on acceptance
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n) begin
            if (tracking) begin
                if (busy) busy_cnt++;
                if (mul_start) start_cnt++;
            end
            if (resp_valid && !in_resp) begin
                in_resp = 1'b1;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_resp", 64'(resp_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_prod", 64'(resp_prod), 64'(e.prod));
                    checkOutput("resp_exc", 64'(resp_exc), 64'(e.exc));
                    checkOutput("resp_timeout", 64'(resp_timeout), 64'(e.tmo));
                    checkOutput("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
                    checkOutput("start_pulses", 64'(start_cnt), 64'(e.starts));
                    checkOutput("busy_cycles", 64'(busy_cnt), 64'(e.lat));
                end
                tracking = 1'b0;
            end else if (!resp_valid) begin
                in_resp = 1'b0;
            end
            if (req_valid && req_ready && !flush) begin
                exp_q.push_back(makeExpected(req_a, req_b, mul_stuck));
                acc_cyc   = cyc;
                busy_cnt  = 0;
                start_cnt = 0;
                tracking  = 1'b1;
            end
            if (flush && exp_q.size() > 0) begin
                exp_q.delete();
                tracking = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!req_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) checkOutput("req_ready_wait", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int guard = 0;
        while ((exp_q.size() != 0 || !req_ready) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) checkOutput("done_wait", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : global_guard
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin : stimulus
        int guard;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'(1));
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("rst_resp_prod", 64'(resp_prod), 64'(0));
        checkOutput("rst_resp_exc", 64'(resp_exc), 64'(0));
        checkOutput("rst_resp_timeout", 64'(resp_timeout), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_mul_start", 64'(mul_start), 64'(0));
        checkOutput("rst_mul_a", 64'(mul_a), 64'(0));
        checkOutput("rst_mul_b", 64'(mul_b), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic 7*6");
        applyStimulus(32'd7, 32'd6);
        waitDone();

        $display("[TB] overflow then negative back-to-back");
        applyStimulus(32'h4000_0000, 32'd4);
        applyStimulus(32'hFFFF_FFFD, 32'd5);
        waitDone();

        $display("[TB] held response");
        resp_ready = 1'b0;
        applyStimulus(32'd1000, 32'd1000);
        guard = 0;
        while (!resp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("held_resp_wait", 64'(resp_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held_valid", 64'(resp_valid), 64'(1));
            checkOutput("held_prod", 64'(resp_prod), 64'(32'd1000000));
            checkOutput("held_exc", 64'(resp_exc), 64'(0));
            checkOutput("held_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("after_pulse_req_ready", 64'(req_ready), 64'(1));
        checkOutput("after_pulse_resp_valid", 64'(resp_valid), 64'(0));
        @(posedge clk); #1;
        resp_ready = 1'b1;

        $display("[TB] flush in BUSY then 3*3");
        applyStimulus(32'd100, 32'd200);
        repeat (15) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_idle", 64'(req_ready), 64'(1));
        checkOutput("flush_resp_valid", 64'(resp_valid), 64'(0));
        @(posedge clk); #1;
        applyStimulus(32'd3, 32'd3);
        waitDone();

        $display("[TB] flush with request in IDLE");
        flush     = 1'b1;
        req_valid = 1'b1;
        req_a     = 32'd9;
        req_b     = 32'd9;
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_req_not_taken", 64'(busy), 64'(0));
        @(posedge clk); #1;

        $display("[TB] watchdog");
        mul_stuck = 1'b1;
        applyStimulus(32'd5, 32'd5);
        waitDone();
        mul_stuck = 1'b0;

        $display("[TB] zero operand");
        applyStimulus(32'd0, 32'd123);
        waitDone();

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
